// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Shares one asynchronous 16-bit SRAM between a write requester (audio
// recorder) and a read requester (DSP playback fetch). The two requesters use a
// level request / one-cycle acknowledge handshake. When both requests are
// pending in IDLE, the port that was not granted last wins, so two requesters
// that never stop asking are served strictly alternately. The first tie goes to
// the read port.
//
// Every SRAM-facing signal comes straight from a flop. This keeps glitches off
// the asynchronous strobes and gives the pad drivers clean timing.
//
// Ports
//   i_clk, i_rst_n          clock; synchronous active-low reset
//   i_wr_req/addr/data      write request (level), address, data
//   o_wr_ack                one-cycle pulse: write finished
//   i_rd_req/addr           read request (level), address
//   o_rd_ack, o_rd_data     one-cycle pulse: o_rd_data holds the new word
//   o_sram_addr             SRAM address; holds the last granted address
//   o_sram_dq_out/_oe       data and output enable for the DQ tristate
//   i_sram_dq               DQ pin value, captured at the end of a read
//   o_sram_{we,oe,ce,lb,ub}_n  SRAM strobes (CE/LB/UB tied active)
//   i_clr_cnt, o_conflicts  saturating count of contended arbitrations
//   o_busy                  high whenever a transaction is in progress
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int WR_PULSE = 2,
  parameter int RD_LAT   = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic [DATA_W-1:0] o_rd_data,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dq_out,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_ce_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n,
  input  logic              i_clr_cnt,
  output logic [7:0]        o_conflicts,
  output logic              o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_RD_WAIT,
    S_RD_DONE
  } state_t;

  typedef enum logic {
    GRANT_WR,
    GRANT_RD
  } grant_t;

  // A single counter times both the write strobe and the read latency, so it
  // is sized for the longer of the two.
  localparam int MAX_CNT = (WR_PULSE > RD_LAT) ? WR_PULSE : RD_LAT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LAT - 1);

  state_t           state;
  grant_t           last_grant;
  logic [CNT_W-1:0] cnt;

  logic both_req;
  logic pick_rd;

  assign both_req = i_wr_req & i_rd_req;
  // On a tie the read port wins only if the write port won the previous
  // arbitration.
  assign pick_rd  = i_rd_req & (~i_wr_req | (last_grant == GRANT_WR));

  // The chip is always selected and both byte lanes are always enabled.
  assign o_sram_ce_n = 1'b0;
  assign o_sram_lb_n = 1'b0;
  assign o_sram_ub_n = 1'b0;

  // NOTE: all state and registered outputs use non-blocking assignments. Every
  // flop then samples values from before the edge, whatever the statement
  // order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      last_grant    <= GRANT_WR;
      cnt           <= '0;
      o_sram_we_n   <= 1'b1;
      o_sram_oe_n   <= 1'b1;
      o_sram_dq_oe  <= 1'b0;
      o_sram_addr   <= '0;
      o_sram_dq_out <= '0;
      o_rd_data     <= '0;
      o_wr_ack      <= 1'b0;
      o_rd_ack      <= 1'b0;
      o_conflicts   <= '0;
      o_busy        <= 1'b0;
    end else begin
      // NOTE: the acks default low each cycle and are raised only on the edge
      // that enters the ack state. This makes them exact one-cycle pulses.
      o_wr_ack <= 1'b0;
      o_rd_ack <= 1'b0;

      // A clear wins over a same-cycle increment.
      if (i_clr_cnt) begin
        o_conflicts <= '0;
      end else if (state == S_IDLE && both_req && o_conflicts != 8'hFF) begin
        o_conflicts <= o_conflicts + 8'd1;
      end

      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (pick_rd) begin
            state       <= S_RD_WAIT;
            last_grant  <= GRANT_RD;
            o_sram_addr <= i_rd_addr;
            o_sram_oe_n <= 1'b0;
            o_busy      <= 1'b1;
          end else if (i_wr_req) begin
            state         <= S_WR_SETUP;
            last_grant    <= GRANT_WR;
            o_sram_addr   <= i_wr_addr;
            o_sram_dq_out <= i_wr_data;
            o_sram_dq_oe  <= 1'b1;
            o_busy        <= 1'b1;
          end
        end

        // Address and data settle for one cycle before WE_N falls.
        S_WR_SETUP: begin
          state       <= S_WR_PULSE;
          o_sram_we_n <= 1'b0;
        end

        S_WR_PULSE: begin
          if (cnt == WR_LAST) begin
            state       <= S_WR_HOLD;
            o_sram_we_n <= 1'b1;
            o_wr_ack    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Data stays driven for one cycle after WE_N rises, to give hold time.
        S_WR_HOLD: begin
          state        <= S_IDLE;
          o_sram_dq_oe <= 1'b0;
          o_busy       <= 1'b0;
        end

        S_RD_WAIT: begin
          if (cnt == RD_LAST) begin
            state       <= S_RD_DONE;
            o_rd_data   <= i_sram_dq;
            o_sram_oe_n <= 1'b1;
            o_rd_ack    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RD_DONE: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end

        default: begin
          state        <= S_IDLE;
          o_sram_we_n  <= 1'b1;
          o_sram_oe_n  <= 1'b1;
          o_sram_dq_oe <= 1'b0;
          o_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Self-checking bench for sram_arbiter. It includes a behavioural model of the
// asynchronous SRAM and a transaction-level reference model. The reference
// model covers the grant choice, latency, read data and the conflict count.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int WR_PULSE = 2;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_req, rd_req, clr_cnt;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack, rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] dq_out, sram_dq;
  logic              dq_oe, we_n, oe_n, ce_n, lb_n, ub_n, busy;
  logic [7:0]        conflicts;

  sram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_PULSE(WR_PULSE), .RD_LAT(RD_LAT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_wr_ack(wr_ack),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_ack(rd_ack),
    .o_rd_data(rd_data),
    .o_sram_addr(sram_addr), .o_sram_dq_out(dq_out), .o_sram_dq_oe(dq_oe),
    .i_sram_dq(sram_dq),
    .o_sram_we_n(we_n), .o_sram_oe_n(oe_n), .o_sram_ce_n(ce_n),
    .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n),
    .i_clr_cnt(clr_cnt), .o_conflicts(conflicts), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // SRAM model (256 words): writes while WE_N is low, drives DQ while OE_N is
  // low, and otherwise shows a marker value so a mistimed capture is visible.
  logic [15:0] mem [0:255] = '{default: 16'h0000};
  always @(posedge clk) if (!we_n) mem[sram_addr[7:0]] <= dq_out;
  assign sram_dq = (!oe_n) ? mem[sram_addr[7:0]] : 16'hDEAD;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int viol     = 0;
  logic mon_en = 1'b0;

  // Strobe-legality monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if ((!we_n && !oe_n) || (!oe_n && dq_oe) || ce_n || lb_n || ub_n)
        viol = viol + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; clr_cnt = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [5:0]  exp_ctl;   // {we_n, oe_n, dq_oe, wr_ack, rd_ack, busy}
    logic [19:0] exp_addr;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  typedef enum logic { P_WR, P_RD } port_t;

  initial begin
    port_t       order [$];
    int          n, budget, acks;
    logic [15:0] model_mem [0:255];
    logic        last_rd, pre_busy, pre_wr, pre_rd, exp_wr, got_wack, got_rack;
    int          model_conf, grant_cyc;

    wr_addr = '0; rd_addr = '0; wr_data = '0;
    do_reset();
    mon_en = 1'b1;

    // ---- reset state -------------------------------------------------------
    check("reset_ctl", 32'({we_n, oe_n, ce_n, lb_n, ub_n, dq_oe, wr_ack, rd_ack, busy}),
          32'(9'b110000000));
    check("reset_data", 32'({sram_addr[15:0], dq_out}), 32'h0);
    check("reset_rd_data_cnt", 32'({rd_data, conflicts}), 32'h0);

    // ---- single write then read-back, cycle by cycle ----------------------
    vecs[0] = '{1'b1, 1'b0, 6'b111001, 20'h00012, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 6'b011001, 20'h00012, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 6'b011001, 20'h00012, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 6'b111101, 20'h00012, 16'h0000};
    vecs[4] = '{1'b0, 1'b0, 6'b110000, 20'h00012, 16'h0000};
    vecs[5] = '{1'b0, 1'b1, 6'b100001, 20'h00012, 16'h0000};
    vecs[6] = '{1'b0, 1'b1, 6'b100001, 20'h00012, 16'h0000};
    vecs[7] = '{1'b0, 1'b1, 6'b110011, 20'h00012, 16'hBEEF};
    vecs[8] = '{1'b0, 1'b0, 6'b110000, 20'h00012, 16'hBEEF};
    wr_addr = 20'h00012; wr_data = 16'hBEEF; rd_addr = 20'h00012;
    for (int i = 0; i < 9; i++) begin
      wr_req = vecs[i].wr;
      rd_req = vecs[i].rd;
      step();
      check($sformatf("vec%0d_ctl", i), 32'({we_n, oe_n, dq_oe, wr_ack, rd_ack, busy}),
            32'(vecs[i].exp_ctl));
      check($sformatf("vec%0d_addr", i), 32'(sram_addr), 32'(vecs[i].exp_addr));
      check($sformatf("vec%0d_rdata", i), 32'(rd_data), 32'(vecs[i].exp_rdata));
      if (i == 0) check("vec0_dq_out", 32'(dq_out), 32'h0000BEEF);
    end
    check("sram_holds_beef", 32'(mem[8'h12]), 32'h0000BEEF);

    // ---- both held from reset: strict alternation R,W,R,... ---------------
    do_reset();
    wr_addr = 20'h00020; rd_addr = 20'h00021; wr_data = 16'h1234;
    wr_req = 1'b1; rd_req = 1'b1;
    budget = 0;
    while (order.size() < 8 && budget < 100) begin
      step();
      budget++;
      if (wr_ack) order.push_back(P_WR);
      if (rd_ack) order.push_back(P_RD);
      if (order.size() >= 8) begin wr_req = 1'b0; rd_req = 1'b0; end
    end
    check("alt_count", 32'(order.size()), 32'd8);
    n = order.size();
    for (int k = 0; k < n; k++)
      check($sformatf("alt_grant%0d", k), 32'(order[k]),
            32'((k % 2 == 0) ? P_RD : P_WR));
    step();
    check("alt_conflicts", 32'(conflicts), 32'd8);
    check("alt_idle", 32'(busy), 32'd0);

    // ---- 300 more contended arbitrations: saturation, then clear ----------
    wr_req = 1'b1; rd_req = 1'b1;
    acks = 0; budget = 0;
    while (acks < 300 && budget < 3000) begin
      step();
      budget++;
      if (wr_ack || rd_ack) acks++;
      if (acks >= 300) begin wr_req = 1'b0; rd_req = 1'b0; end
    end
    check("sat_acks", 32'(acks), 32'd300);
    step();
    check("sat_conflicts", 32'(conflicts), 32'd255);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check("clr_conflicts", 32'(conflicts), 32'd0);

    // Clear wins over a same-cycle contended arbitration.
    wr_req = 1'b1; rd_req = 1'b1; clr_cnt = 1'b1;
    step();
    wr_req = 1'b0; rd_req = 1'b0; clr_cnt = 1'b0;
    check("clr_priority", 32'({busy, conflicts}), 32'({1'b1, 8'd0}));
    repeat (6) step();
    check("clr_priority_after", 32'({busy, conflicts}), 32'd0);

    // ---- reset asserted during WR_PULSE -----------------------------------
    wr_addr = 20'h00033; wr_data = 16'h5A5A; wr_req = 1'b1;
    step();
    step();
    check("rst_mid_in_pulse", 32'(we_n), 32'd0);
    rst_n = 1'b0;
    step();
    check("rst_mid_ctl", 32'({we_n, dq_oe, busy, wr_ack}), 32'(4'b1000));
    rst_n = 1'b1; wr_req = 1'b0;
    acks = 0;
    repeat (6) begin step(); if (wr_ack) acks++; end
    check("rst_mid_no_ack", 32'(acks), 32'd0);

    // ---- request dropped one cycle after grant ----------------------------
    wr_addr = 20'h00044; wr_data = 16'hC0DE; wr_req = 1'b1;
    step();
    wr_req = 1'b0;
    acks = 0;
    repeat (8) begin step(); if (wr_ack) acks++; end
    check("drop_wr_acks", 32'(acks), 32'd1);
    check("drop_wr_idle", 32'(busy), 32'd0);
    rd_addr = 20'h00044; rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    acks = 0;
    repeat (8) begin step(); if (rd_ack) acks++; end
    check("drop_rd_acks", 32'(acks), 32'd1);
    check("drop_rd_data", 32'(rd_data), 32'h0000C0DE);

    // ---- randomized traffic against the reference model -------------------
    do_reset();
    for (int a = 0; a < 256; a++) model_mem[a] = 16'h0000;
    last_rd = 1'b0; model_conf = 0; grant_cyc = cyc;
    for (int t = 0; t < 3000; t++) begin
      pre_busy = busy; pre_wr = wr_req; pre_rd = rd_req;
      step();
      if (!pre_busy && (pre_wr || pre_rd)) begin
        exp_wr = pre_wr && (!pre_rd || last_rd);
        check("rnd_grant_port", 32'({busy, dq_oe}), 32'({1'b1, exp_wr}));
        check("rnd_grant_addr", 32'(sram_addr), 32'(exp_wr ? wr_addr : rd_addr));
        last_rd = !exp_wr;
        if (pre_wr && pre_rd && model_conf < 255) model_conf++;
        grant_cyc = cyc;
      end
      got_wack = wr_ack;
      got_rack = rd_ack;
      if (got_wack) begin
        check("rnd_wr_lat", 32'(cyc - grant_cyc), 32'(WR_PULSE + 1));
        model_mem[wr_addr[7:0]] = wr_data;
        wr_req = 1'b0;
      end
      if (got_rack) begin
        check("rnd_rd_lat", 32'(cyc - grant_cyc), 32'(RD_LAT));
        check("rnd_rd_data", 32'(rd_data), 32'(model_mem[rd_addr[7:0]]));
        rd_req = 1'b0;
      end
      if (!wr_req && !got_wack && ($urandom % 4 == 0)) begin
        wr_req  = 1'b1;
        wr_addr = 20'h00080 + 20'($urandom % 16);
        wr_data = 16'($urandom);
      end
      if (!rd_req && !got_rack && ($urandom % 3 == 0)) begin
        rd_req  = 1'b1;
        rd_addr = 20'h00080 + 20'($urandom % 16);
      end
    end
    check("rnd_conflicts", 32'(conflicts), 32'(model_conf));
    check("strobe_violations", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
